sphere_hit_scan: RTL

SPHERE_HIT_SCAN -- requirements
Module: sphere_hit_scan

---
 rtl/sphere_hit_scan.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sphere_hit_scan.sv
// rtl/sphere_hit_scan.sv - ray/sphere intersection scan over a 4-entry sphere bank
module sphere_hit_scan #(
  parameter logic signed [63:0] RADIUS_SQ = 64'd400 << 32,
  parameter logic [23:0]        BG_COLOR  = 24'h000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0][63:0] Ray_dir,
  output logic [1:0]       Read_index,
  input  logic [2:0][63:0] Sphere_pos,
  input  logic [2:0][7:0]  Sphere_col,
  output logic             Busy,
  output logic             Done,
  output logic             Hit,
  output logic [1:0]       Hit_index,
  output logic [2:0][7:0]  Pixel_col
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DOT, S_TEST, S_DONE} state_t;

  state_t                state;
  logic [1:0]            k;
  logic [2:0][63:0]      dir;
  logic [2:0][63:0]      pos;
  logic [23:0]           col;
  logic signed [63:0]    dd, b, cc;
  logic                  best_valid;
  logic [1:0]            best_k;
  logic signed [63:0]    best_cc;
  logic [23:0]           best_col;

  // 32.32 multiply: sign-extend to 128 bits, keep product bits [95:32]
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] x,
                                                input logic signed [63:0] y);
    return 64'(({{64{x[63]}}, x} * {{64{y[63]}}, y}) >> 32);
  endfunction

  function automatic logic signed [63:0] fx_dot(input logic [2:0][63:0] u,
                                                input logic [2:0][63:0] v);
    return fx_mul(u[0], v[0]) + fx_mul(u[1], v[1]) + fx_mul(u[2], v[2]);
  endfunction

  logic        hit_k, take, fin_valid;
  logic [1:0]  fin_k;
  logic [23:0] fin_col;

  // Best record including the sphere under test, so k==3 lands in the DONE outputs
  always_comb begin
    hit_k     = (b > 64'sd0) && (fx_mul(b, b) >= fx_mul(dd, cc - RADIUS_SQ));
    take      = hit_k && (!best_valid || (cc < best_cc));
    fin_valid = take || best_valid;
    fin_k     = take ? k : best_k;
    fin_col   = take ? col : best_col;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      k          <= 2'd0;
      Read_index <= 2'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Hit        <= 1'b0;
      Hit_index  <= 2'd0;
      Pixel_col  <= BG_COLOR;
      best_valid <= 1'b0;
      best_k     <= 2'd0;
      best_cc    <= 64'sd0;
      best_col   <= BG_COLOR;
      dir        <= '0;
      pos        <= '0;
      col        <= '0;
      dd         <= 64'sd0;
      b          <= 64'sd0;
      cc         <= 64'sd0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            dir        <= Ray_dir;
            k          <= 2'd0;
            Read_index <= 2'd0;
            best_valid <= 1'b0;
            best_k     <= 2'd0;
            best_cc    <= 64'sd0;
            best_col   <= BG_COLOR;
            Busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          pos   <= Sphere_pos;
          col   <= Sphere_col;
          state <= S_DOT;
        end
        S_DOT: begin
          dd    <= fx_dot(dir, dir);
          b     <= fx_dot(dir, pos);
          cc    <= fx_dot(pos, pos);
          state <= S_TEST;
        end
        S_TEST: begin
          if (take) begin
            best_valid <= 1'b1;
            best_k     <= k;
            best_cc    <= cc;
            best_col   <= col;
          end
          if (k == 2'd3) begin
            Read_index <= 2'd0;
            Done       <= 1'b1;
            Hit        <= fin_valid;
            Hit_index  <= fin_valid ? fin_k : 2'd0;
            Pixel_col  <= fin_valid ? fin_col : BG_COLOR;
            state      <= S_DONE;
          end else begin
            k          <= k + 2'd1;
            Read_index <= k + 2'd1;
            state      <= S_FETCH;
          end
        end
        S_DONE: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy       <= 1'b0;
          Read_index <= 2'd0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
